rng_sched: RTL and testbench
============================

# rng_sched

Sequencing and sharing controller for the 4-bit LFSR/NLFSR random core. Owns core seeding and warm-up, then serves 8-bit random words to two requesters under round-robin arbitration, assembling each word from two consecutive 4-bit samples of the source each requester selects. Sits between the RNG core instances and the consumers of random data.

## Interface

Parameters:
- WARMUP, 8: cycles of core output discarded after every (re)seed; 1..15.
- RESET_SEED, 4'h1: seed used after reset and substituted for an all-zero seed; must be non-zero.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- seed_load  in  1  single-cycle pulse: latch seed and reseed the core.
- seed  in  4  seed value, sampled only when seed_load=1.
- rng_reset  out  1  drives the core reset input.
- rng_seed  out  4  drives the core seed input; equals the internal seed register.
- lfsr_nib  in  4  core LFSR output.
- nlfsr_nib  in  4  core NLFSR output.
- req  in  2  per-requester request level; held high until the matching gnt bit.
- src  in  2  per-requester source: 0 = LFSR, 1 = NLFSR; sampled at the winning arbitration edge.
- gnt  out  2  one-hot, single-cycle grant; data_out is valid in that cycle.
- data_out  out  8  assembled random word.
- ready  out  1  high in IDLE only.

## Operation

- States: SEED, WARM, IDLE, HI, LO, GNT.
- Reset: state=SEED, seed_reg=RESET_SEED, warm counter=0, last_grant=1 (req[0] wins first tie), gnt=0, data_out=0, ready=0. rng_reset = reset OR (state==SEED).
- SEED: one cycle; rng_reset=1, rng_seed=seed_reg; next WARM with counter=WARMUP-1.
- WARM: counter decrements each cycle; at 0 go to IDLE. Core outputs ignored.
- IDLE: ready=1. If req!=0, arbitrate: a single requester wins; with both, the winner is the one not equal to last_grant. Latch winner index and src[winner]; next HI.
- HI: data_out[7:4] <= selected nibble; next LO.
- LO: data_out[3:0] <= selected nibble; next GNT.
- GNT: gnt[winner]=1 for this cycle only; last_grant <= winner; next IDLE.
- seed_load: highest priority, any state except during reset. seed_reg <= (seed==0 ? RESET_SEED : seed); state <= SEED. Any in-flight word is aborted with no gnt; requesters keep req asserted and are re-served after warm-up.
- req dropped mid-transaction: the transaction still completes and gnt is issued; the word is discarded by the requester.
- req asserted during SEED/WARM: held off until IDLE; no grant.
- reset mid-operation: immediate return to reset values; no gnt.
- data_out holds its last value outside HI/LO. It is only meaningful while gnt!=0.

## Timing

- Reset deassert edge E: SEED in cycle E to E+1, WARM for WARMUP cycles, IDLE from edge E+1+WARMUP.
- Request latency: req sampled at IDLE edge k -> gnt high in the cycle after edge k+3. The word uses the nibbles present at edges k+1 and k+2.
- Throughput: at most one word per 4 cycles, because IDLE lasts at least one cycle between grants.
- With both requesters asserting continuously, grants alternate strictly 0,1,0,1...
- seed_load at edge j -> rng_reset high in cycle j to j+1 -> ready again at edge j+1+WARMUP.

## Structure

- Package rng_sched_pkg: state enum, SRC_LFSR/SRC_NLFSR constants, default WARMUP and RESET_SEED.
- Sub-module rr_arb2: 2-way round-robin arbiter (req, last_grant -> one-hot winner), purely combinational.
- Top-level rng_sched: FSM, warm counter, seed register, nibble assembly.

## Test plan

- Reset, no requests -> rng_reset high for 1 cycle after reset release with rng_seed=4'h1; ready rises exactly WARMUP+1 cycles after release; gnt stays 0.
- IDLE, req=2'b01, src[0]=0, lfsr_nib=4'hA at HI edge and 4'h5 at LO edge -> gnt=2'b01 3 cycles after the req edge, data_out=8'hA5.
- req=2'b11 held, src=2'b10 -> grants alternate 01,10,01,10; requester 1 words are built from nlfsr_nib; one grant every 4 cycles.
- seed_load with seed=4'h0 while in LO -> no gnt; rng_seed=4'h1; rng_reset pulses; held req is granted after warm-up.
- seed_load with seed=4'h9 and reset asserted together -> reset wins, rng_seed=4'h1; a later standalone seed_load with 4'h9 gives rng_seed=4'h9.
- req[0] dropped in HI -> gnt[0] still issued in GNT; next IDLE serves req[1] if it is asserted.

Source files
------------

// File: rtl/rng_sched_pkg.sv
`default_nettype none
// ============================================================================
// rng_sched_pkg : shared constants and state encoding for the RNG scheduler
// Rev 1.0
// ============================================================================
package rng_sched_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_SEED = 3'd0;
    localparam state_t ST_WARM = 3'd1;
    localparam state_t ST_IDLE = 3'd2;
    localparam state_t ST_HI   = 3'd3;
    localparam state_t ST_LO   = 3'd4;
    localparam state_t ST_GNT  = 3'd5;

    localparam logic SRC_LFSR  = 1'b0;
    localparam logic SRC_NLFSR = 1'b1;

    localparam int unsigned DEF_WARMUP     = 8;
    localparam logic [3:0]  DEF_RESET_SEED = 4'h1;

    function automatic logic [1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rng_sched_rr_arb2.sv
`default_nettype none
// ============================================================================
// rr_arb2 : two-way round-robin arbiter, one-hot winner, purely combinational
// Rev 1.0
// ============================================================================
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] win
);

    // On a tie the requester that was not served last time wins.
    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = last_grant ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rng_sched.sv
`default_nettype none
// ============================================================================
// rng_sched : seeds and warms the RNG core, then serves 8-bit words to two
//             requesters under round-robin arbitration
// Rev 1.0
// ============================================================================
module rng_sched
    import rng_sched_pkg::*;
#(
    parameter int unsigned WARMUP     = DEF_WARMUP,
    parameter logic [3:0]  RESET_SEED = DEF_RESET_SEED
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       seed_load,
    input  logic [3:0] seed,
    output logic       rng_reset,
    output logic [3:0] rng_seed,
    input  logic [3:0] lfsr_nib,
    input  logic [3:0] nlfsr_nib,
    input  logic [1:0] req,
    input  logic [1:0] src,
    output logic [1:0] gnt,
    output logic [7:0] data_out,
    output logic       ready
);

    localparam logic [3:0] WARM_INIT = 4'(WARMUP - 1);

    state_t     state_q,      state_d;
    logic [3:0] seed_reg_q,   seed_reg_d;
    logic [3:0] warm_cnt_q,   warm_cnt_d;
    logic       last_grant_q, last_grant_d;
    logic       winner_q,     winner_d;
    logic       src_sel_q,    src_sel_d;
    logic [1:0] gnt_q,        gnt_d;
    logic [7:0] data_q,       data_d;

    logic [1:0] w_win;
    logic [3:0] w_nib;

    rr_arb2 u_arb (
        .req        (req),
        .last_grant (last_grant_q),
        .win        (w_win)
    );

    assign w_nib = (src_sel_q == SRC_NLFSR) ? nlfsr_nib : lfsr_nib;

    always_comb begin
        state_d      = state_q;
        seed_reg_d   = seed_reg_q;
        warm_cnt_d   = warm_cnt_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        src_sel_d    = src_sel_q;
        gnt_d        = 2'b00;
        data_d       = data_q;

        case (state_q)
            ST_SEED: begin
                warm_cnt_d = WARM_INIT;
                state_d    = ST_WARM;
            end
            ST_WARM: begin
                if (warm_cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    warm_cnt_d = warm_cnt_q - 4'd1;
                end
            end
            ST_IDLE: begin
                if (req != 2'b00) begin
                    winner_d  = w_win[1];
                    src_sel_d = src[w_win[1]];
                    state_d   = ST_HI;
                end
            end
            ST_HI: begin
                data_d[7:4] = w_nib;
                state_d     = ST_LO;
            end
            ST_LO: begin
                data_d[3:0] = w_nib;
                state_d     = ST_GNT;
            end
            ST_GNT: begin
                gnt_d        = idx_to_onehot(winner_q);
                last_grant_d = winner_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_SEED;
            end
        endcase

        // A reseed overrides whatever the FSM was doing; an in-flight word is dropped.
        if (seed_load) begin
            seed_reg_d   = (seed == 4'h0) ? RESET_SEED : seed;
            state_d      = ST_SEED;
            gnt_d        = 2'b00;
            data_d       = data_q;
            last_grant_d = last_grant_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_SEED;
            seed_reg_q   <= RESET_SEED;
            warm_cnt_q   <= 4'd0;
            last_grant_q <= 1'b1;
            winner_q     <= 1'b0;
            src_sel_q    <= SRC_LFSR;
            gnt_q        <= 2'b00;
            data_q       <= 8'h00;
        end else begin
            state_q      <= state_d;
            seed_reg_q   <= seed_reg_d;
            warm_cnt_q   <= warm_cnt_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            src_sel_q    <= src_sel_d;
            gnt_q        <= gnt_d;
            data_q       <= data_d;
        end
    end

    assign rng_reset = reset | (state_q == ST_SEED);
    assign rng_seed  = seed_reg_q;
    assign gnt       = gnt_q;
    assign data_out  = data_q;
    assign ready     = (state_q == ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rng_sched.sv
`default_nettype none
// ============================================================================
// tb_rng_sched : directed self-checking bench for rng_sched
// Rev 1.0
// ============================================================================
module tb_rng_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       seed_load;
    logic [3:0] seed;
    logic       rng_reset;
    logic [3:0] rng_seed;
    logic [3:0] lfsr_nib;
    logic [3:0] nlfsr_nib;
    logic [1:0] req;
    logic [1:0] src;
    logic [1:0] gnt;
    logic [7:0] data_out;
    logic       ready;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int t_prev;
    int t_now;

    rng_sched dut (
        .clk       (clk),
        .reset     (reset),
        .seed_load (seed_load),
        .seed      (seed),
        .rng_reset (rng_reset),
        .rng_seed  (rng_seed),
        .lfsr_nib  (lfsr_nib),
        .nlfsr_nib (nlfsr_nib),
        .req       (req),
        .src       (src),
        .gnt       (gnt),
        .data_out  (data_out),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Called in the cycle right after the edge that entered SEED.
    task automatic wait_ready(input string tag);
        int n       = 0;
        int gnt_cnt = 0;
        int rr_cnt  = 0;
        if (rng_reset) rr_cnt++;
        while (!ready && n < 40) begin
            step();
            n++;
            if (gnt != 2'b00) gnt_cnt++;
            if (rng_reset) rr_cnt++;
        end
        chk_eq({tag, "_ready_lat"}, n, 9);
        chk_eq({tag, "_no_gnt"}, gnt_cnt, 0);
        chk_eq({tag, "_rng_reset_pulse"}, rr_cnt, 1);
    endtask

    // Starts in an IDLE cycle; ends in the cycle where gnt is expected high.
    task automatic run_txn(input string tag, input logic [1:0] req_v, input logic [1:0] src_v,
                           input logic [3:0] hi_l, input logic [3:0] hi_n,
                           input logic [3:0] lo_l, input logic [3:0] lo_n,
                           input logic [1:0] exp_gnt, input logic [7:0] exp_data,
                           output int t_gnt);
        req = req_v;
        src = src_v;
        step();
        src       = ~src_v;
        lfsr_nib  = hi_l;
        nlfsr_nib = hi_n;
        step();
        lfsr_nib  = lo_l;
        nlfsr_nib = lo_n;
        step();
        chk_eq({tag, "_gnt_early"}, gnt, 2'b00);
        step();
        chk_eq({tag, "_gnt"}, gnt, exp_gnt);
        chk_eq({tag, "_data"}, data_out, exp_data);
        t_gnt = cyc;
        req   = req_v & ~exp_gnt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        seed_load = 1'b0;
        seed      = 4'h0;
        lfsr_nib  = 4'h0;
        nlfsr_nib = 4'h0;
        req       = 2'b00;
        src       = 2'b00;
        repeat (3) step();

        chk_eq("rst_gnt", gnt, 2'b00);
        chk_eq("rst_data", data_out, 8'h00);
        chk_eq("rst_ready", ready, 1'b0);
        chk_eq("rst_seed", rng_seed, 4'h1);
        chk_eq("rst_rng_reset", rng_reset, 1'b1);
        reset = 1'b0;
        #1;
        chk_eq("seed_rng_seed", rng_seed, 4'h1);
        wait_ready("boot");

        // single requester, LFSR source
        run_txn("single", 2'b01, 2'b00, 4'hA, 4'h3, 4'h5, 4'hC, 2'b01, 8'hA5, t_now);
        chk_eq("single_ready", ready, 1'b1);
        step();
        chk_eq("single_gnt_clear", gnt, 2'b00);

        // both requesting, requester 1 on NLFSR: strict alternation every 4 cycles
        run_txn("alt_a", 2'b11, 2'b10, 4'h1, 4'hE, 4'h2, 4'h7, 2'b10, 8'hE7, t_prev);
        run_txn("alt_b", 2'b11, 2'b10, 4'h9, 4'h4, 4'hB, 4'h6, 2'b01, 8'h9B, t_now);
        chk_eq("alt_b_period", t_now - t_prev, 4);
        t_prev = t_now;
        run_txn("alt_c", 2'b11, 2'b10, 4'h3, 4'h8, 4'hD, 4'hF, 2'b10, 8'h8F, t_now);
        chk_eq("alt_c_period", t_now - t_prev, 4);
        t_prev = t_now;
        run_txn("alt_d", 2'b11, 2'b10, 4'hC, 4'h1, 4'h0, 4'h2, 2'b01, 8'hC0, t_now);
        chk_eq("alt_d_period", t_now - t_prev, 4);
        req = 2'b00;
        step();
        chk_eq("alt_gnt_clear", gnt, 2'b00);

        // reset together with seed_load in the middle of a word
        req = 2'b01;
        src = 2'b00;
        step();
        reset     = 1'b1;
        seed_load = 1'b1;
        seed      = 4'h9;
        step();
        chk_eq("rstld_seed", rng_seed, 4'h1);
        chk_eq("rstld_gnt", gnt, 2'b00);
        chk_eq("rstld_data", data_out, 8'h00);
        chk_eq("rstld_ready", ready, 1'b0);
        reset     = 1'b0;
        seed_load = 1'b0;
        req       = 2'b00;
        wait_ready("rstld");

        // standalone reseed
        seed_load = 1'b1;
        seed      = 4'h9;
        step();
        seed_load = 1'b0;
        chk_eq("ld9_seed", rng_seed, 4'h9);
        chk_eq("ld9_ready", ready, 1'b0);
        wait_ready("ld9");

        // zero reseed while in LO aborts the word; held req is served after warm-up
        req = 2'b01;
        src = 2'b00;
        step();
        step();
        seed_load = 1'b1;
        seed      = 4'h0;
        step();
        seed_load = 1'b0;
        chk_eq("ld0_seed", rng_seed, 4'h1);
        chk_eq("ld0_gnt", gnt, 2'b00);
        wait_ready("ld0");
        run_txn("ld0_resume", 2'b01, 2'b00, 4'h2, 4'h9, 4'h4, 4'h9, 2'b01, 8'h24, t_now);

        // requester 1 served, then req[0] dropped during HI still gets its grant
        run_txn("pre_drop", 2'b10, 2'b10, 4'h0, 4'hB, 4'h0, 4'h3, 2'b10, 8'hB3, t_now);
        req = 2'b11;
        src = 2'b00;
        step();
        req       = 2'b10;
        lfsr_nib  = 4'h6;
        nlfsr_nib = 4'hF;
        step();
        lfsr_nib  = 4'h7;
        nlfsr_nib = 4'hE;
        step();
        step();
        chk_eq("drop_gnt", gnt, 2'b01);
        chk_eq("drop_data", data_out, 8'h67);
        t_prev = cyc;
        run_txn("after_drop", 2'b10, 2'b10, 4'h1, 4'hD, 4'h1, 4'h2, 2'b10, 8'hD2, t_now);
        chk_eq("after_drop_period", t_now - t_prev, 4);
        req = 2'b00;
        step();
        chk_eq("final_gnt_clear", gnt, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
